// File: rtl/data_memory_lsu_pkg.sv
// Shared types and helpers for the load/store data memory.
// Lane masks and load extension are computed at a fixed maximum width.
package data_memory_lsu_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Widest supported data word; callers slice results down to W.
  localparam int MAX_W   = 256;
  localparam int MAX_B   = MAX_W / 8;
  localparam int MAX_OFF = $clog2(MAX_B);

  // Byte-enable mask for an access of 2**size bytes at byte lane.
  function automatic logic [MAX_B-1:0] be_mask(
    input logic [1:0]         size,
    input logic [MAX_OFF-1:0] lane
  );
    logic [MAX_B-1:0] m;
    m = (MAX_B'(1) << (32'd1 << size)) - MAX_B'(1);
    return m << lane;
  endfunction

  // Extend the low 8*2**size bits of data to the full width.
  function automatic logic [MAX_W-1:0] extend(
    input logic [MAX_W-1:0] data,
    input logic [1:0]       size,
    input logic             is_unsigned
  );
    logic [MAX_W-1:0] r;
    logic             fill;
    int               bits;
    bits = 8 << size;
    fill = is_unsigned ? 1'b0 : data[bits-1];
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < bits) ? data[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_lsu_array.sv
// Byte-enabled single-port RAM with a registered read port.
// With DATA_MEMORY_LSU_PARITY_EN each byte lane also keeps an even-parity bit.
module data_memory_lsu_array #(
  parameter int W = 32,
  parameter int N = 5,
  localparam int BYTES = W / 8,
  localparam int DEPTH = 2 ** N
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [BYTES-1:0] be,
  input  logic [N-1:0]     addr,
  input  logic [W-1:0]     wdata,
`ifdef DATA_MEMORY_LSU_PARITY_EN
  output logic [BYTES-1:0] rpar,
`endif
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

`ifdef DATA_MEMORY_LSU_PARITY_EN
  logic [BYTES-1:0] mem_par [DEPTH];
`endif

  // Per-lane write and registered whole-word read on the same port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
`ifdef DATA_MEMORY_LSU_PARITY_EN
          mem_par[addr][b] <= ^wdata[8*b +: 8];
`endif
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
`ifdef DATA_MEMORY_LSU_PARITY_EN
      rpar <= mem_par[addr];
`endif
    end
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed load/store front end with hardware clear over a data RAM.
// Optional per-lane parity: define DATA_MEMORY_LSU_PARITY_EN.
module data_memory_lsu
  import data_memory_lsu_pkg::*;
#(
  parameter int         W        = 32,
  parameter int         N        = 5,
  parameter logic [W-1:0] INIT_VAL = '0,
  localparam int BYTES = W / 8,
  localparam int OFF   = $clog2(BYTES),
  localparam int A     = N + OFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [A-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         resp_valid,
  output logic [W-1:0] resp_data,
  output logic         resp_err,
  output logic         init_busy
);

  state_t state_q, state_d;
  logic [N-1:0] idx_q, idx_d;

  logic         accept;
  logic         size_ok;
  logic         aligned;
  logic         legal;
  logic [A-1:0] low_mask;
  logic [OFF-1:0] lane;
  logic [N-1:0] widx;

  logic [MAX_OFF-1:0] lane_ext;
  logic [MAX_B-1:0]   be_full;
  logic [W-1:0]       rep_data;

  logic             arr_we;
  logic             arr_re;
  logic [BYTES-1:0] arr_be;
  logic [N-1:0]     arr_addr;
  logic [W-1:0]     arr_wdata;
  logic [W-1:0]     arr_rdata;
`ifdef DATA_MEMORY_LSU_PARITY_EN
  logic [BYTES-1:0] arr_rpar;
`endif

  logic           rv_q;
  logic           load_q;
  logic           err_q;
  logic           uns_q;
  logic [1:0]     size_q;
  logic [OFF-1:0] lane_q;

  logic [W-1:0]     shifted;
  logic [MAX_W-1:0] ext_in;
  logic [MAX_W-1:0] ext_out;
  logic             par_err;
  logic             unused_hi;

  assign lane      = req_addr[OFF-1:0];
  assign widx      = req_addr[A-1:OFF];
  assign req_ready = !rst && (state_q == RUN) && !clr;
  assign init_busy = rst || (state_q == INIT);
  assign accept    = req_valid && req_ready;
  assign size_ok   = int'(req_size) <= OFF;
  assign low_mask  = (A'(1) << req_size) - A'(1);
  assign aligned   = (req_addr & low_mask) == '0;
  assign legal     = size_ok && aligned;

  // Store lane steering: mask from size/offset, data replicated to every lane.
  always_comb begin
    lane_ext = '0;
    lane_ext[OFF-1:0] = lane;
    be_full = be_mask(req_size, lane_ext);
    rep_data = '0;
    for (int b = 0; b < BYTES; b++) begin
      rep_data[8*b +: 8] =
        req_wdata[8*(b & ((32'd1 << req_size) - 1)) +: 8];
    end
  end

  // Clear sequencer / request FSM: next state and array controls.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_be    = '0;
    arr_addr  = widx;
    arr_wdata = rep_data;
    unique case (state_q)
      INIT: begin
        arr_we    = 1'b1;
        arr_be    = '1;
        arr_addr  = idx_q;
        arr_wdata = INIT_VAL;
        if (clr) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + N'(1);
          if (idx_q == '1) state_d = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = INIT;
          idx_d   = '0;
        end else if (accept) begin
          arr_we = req_we && legal;
          arr_be = be_full[BYTES-1:0];
          arr_re = !req_we;
        end
      end
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase
  end

  // FSM state and clear index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Response tracking: access attributes travel with the registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q   <= 1'b0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= '0;
      lane_q <= '0;
    end else begin
      rv_q <= accept;
      if (accept) begin
        load_q <= !req_we;
        err_q  <= !legal;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        lane_q <= lane;
      end
    end
  end

  data_memory_lsu_array #(
    .W(W),
    .N(N)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
`ifdef DATA_MEMORY_LSU_PARITY_EN
    .rpar  (arr_rpar),
`endif
    .rdata (arr_rdata)
  );

  // Load path: shift the addressed lane down, then extend.
  always_comb begin
    shifted = arr_rdata >> {lane_q, 3'b000};
    ext_in = '0;
    ext_in[W-1:0] = shifted;
    ext_out = extend(ext_in, size_q, uns_q);
  end

  // Parity check across every lane of the read word.
  always_comb begin
    par_err = 1'b0;
`ifdef DATA_MEMORY_LSU_PARITY_EN
    for (int b = 0; b < BYTES; b++) begin
      if ((^arr_rdata[8*b +: 8]) != arr_rpar[b]) par_err = 1'b1;
    end
`endif
  end

  assign unused_hi = ^{ext_out[MAX_W-1:W], be_full[MAX_B-1:BYTES]};

  assign resp_valid = rv_q;
  assign resp_err   = rv_q && (err_q || (load_q && par_err));
  assign resp_data  = (rv_q && load_q && !err_q) ? ext_out[W-1:0] : '0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed self-checking bench for data_memory_lsu (W=32, N=5).
// Inputs change on negedge, outputs sampled on negedge.
module tb_data_memory_lsu;

  localparam int W = 32;
  localparam int N = 5;
  localparam int A = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [A-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic [W-1:0] resp_data;
  logic         resp_err;
  logic         init_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_lsu #(
    .W(W),
    .N(N),
    .INIT_VAL(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .init_busy    (init_busy)
  );

  task automatic do_req(
    input  logic         we,
    input  logic [1:0]   sz,
    input  logic         uns,
    input  logic [A-1:0] a,
    input  logic [W-1:0] wd,
    output logic         rdy,
    output logic         v,
    output logic [W-1:0] d,
    output logic         e
  );
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    #1 rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_we = 1'b0;
    @(negedge clk);
    v = resp_valid;
    d = resp_data;
    e = resp_err;
  endtask

  task automatic count_busy(output int cnt, output logic rdy_after);
    cnt = 1;
    rdy_after = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (init_busy && !req_ready) begin
        cnt++;
      end else begin
        rdy_after = req_ready && !init_busy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic r, v, e, ra;
    logic [W-1:0] d;
    int cnt;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (init_busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
        resp_data !== '0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b rdy=%b v=%b d=%h e=%b want 1 0 0 0 0",
               init_busy, req_ready, resp_valid, resp_data, resp_err);
    end
    rst = 1'b0;
    count_busy(cnt, ra);
    checks++;
    if (cnt != 32 || ra !== 1'b1) begin
      failures++;
      $display("FAIL reset_init_len: cycles=%0d ready_after=%b want 32 1", cnt, ra);
    end
    do_req(1'b0, 2'd2, 1'b0, 7'h7C, '0, r, v, d, e);
    checks++;
    if (r !== 1'b1 || v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      failures++;
      $display("FAIL reset_load_7c: rdy=%b v=%b d=%h e=%b want 1 1 00000000 0", r, v, d, e);
    end
  endtask

  task automatic test_byte_ext;
    logic r, v, e;
    logic [W-1:0] d;
    do_req(1'b1, 2'd2, 1'b0, 7'h10, 32'h800000F1, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      failures++;
      $display("FAIL store_resp: v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    do_req(1'b0, 2'd0, 1'b0, 7'h10, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'hFFFFFFF1 || e !== 1'b0) begin
      failures++;
      $display("FAIL byte_signed: v=%b d=%h e=%b want 1 fffffff1 0", v, d, e);
    end
    do_req(1'b0, 2'd0, 1'b1, 7'h10, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h000000F1 || e !== 1'b0) begin
      failures++;
      $display("FAIL byte_unsigned: v=%b d=%h e=%b want 1 000000f1 0", v, d, e);
    end
    do_req(1'b0, 2'd0, 1'b0, 7'h13, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'hFFFFFF80 || e !== 1'b0) begin
      failures++;
      $display("FAIL byte3_signed: v=%b d=%h e=%b want 1 ffffff80 0", v, d, e);
    end
    do_req(1'b0, 2'd1, 1'b1, 7'h12, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h00008000 || e !== 1'b0) begin
      failures++;
      $display("FAIL half_unsigned: v=%b d=%h e=%b want 1 00008000 0", v, d, e);
    end
  endtask

  task automatic test_partial_store;
    logic r, v, e;
    logic [W-1:0] d;
    do_req(1'b1, 2'd2, 1'b0, 7'h10, 32'h11223344, r, v, d, e);
    do_req(1'b1, 2'd1, 1'b0, 7'h12, 32'h0000BEEF, r, v, d, e);
    do_req(1'b0, 2'd2, 1'b0, 7'h10, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'hBEEF3344 || e !== 1'b0) begin
      failures++;
      $display("FAIL half_store: v=%b d=%h e=%b want 1 beef3344 0", v, d, e);
    end
    do_req(1'b1, 2'd0, 1'b0, 7'h11, 32'h0000005A, r, v, d, e);
    do_req(1'b0, 2'd2, 1'b0, 7'h10, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'hBEEF5A44 || e !== 1'b0) begin
      failures++;
      $display("FAIL byte_store: v=%b d=%h e=%b want 1 beef5a44 0", v, d, e);
    end
    do_req(1'b0, 2'd1, 1'b0, 7'h12, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'hFFFFBEEF || e !== 1'b0) begin
      failures++;
      $display("FAIL half_signed: v=%b d=%h e=%b want 1 ffffbeef 0", v, d, e);
    end
  endtask

  task automatic test_misalign;
    logic r, v, e;
    logic [W-1:0] d;
    do_req(1'b1, 2'd2, 1'b0, 7'h04, 32'hA5A5A5A5, r, v, d, e);
    do_req(1'b1, 2'd2, 1'b0, 7'h05, 32'hDEADBEEF, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      failures++;
      $display("FAIL mis_store: v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
    do_req(1'b0, 2'd1, 1'b0, 7'h03, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      failures++;
      $display("FAIL mis_load: v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
    do_req(1'b0, 2'd2, 1'b0, 7'h04, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'hA5A5A5A5 || e !== 1'b0) begin
      failures++;
      $display("FAIL mis_unchanged: v=%b d=%h e=%b want 1 a5a5a5a5 0", v, d, e);
    end
    do_req(1'b0, 2'd3, 1'b0, 7'h08, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      failures++;
      $display("FAIL bad_size: v=%b d=%h e=%b want 1 00000000 1", v, d, e);
    end
    do_req(1'b0, 2'd1, 1'b1, 7'h06, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0000A5A5 || e !== 1'b0) begin
      failures++;
      $display("FAIL half_hi: v=%b d=%h e=%b want 1 0000a5a5 0", v, d, e);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_addr = 7'h20;
    req_wdata = 32'hCAFEBABE;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_store: v=%b d=%h e=%b want 1 00000000 0",
               resp_valid, resp_data, resp_err);
    end
    req_we = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hCAFEBABE || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_load: v=%b d=%h e=%b want 1 cafebabe 0",
               resp_valid, resp_data, resp_err);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pulse: v=%b want 0", resp_valid);
    end
  endtask

  task automatic test_clear;
    logic r, v, e, ra, rdy;
    logic [W-1:0] d;
    int cnt;
    @(negedge clk);
    clr = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'd2;
    req_addr = 7'h20;
    #1 rdy = req_ready;
    @(negedge clk);
    clr = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (rdy !== 1'b0 || resp_valid !== 1'b0 || init_busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_reject: rdy=%b v=%b busy=%b want 0 0 1", rdy, resp_valid, init_busy);
    end
    count_busy(cnt, ra);
    checks++;
    if (cnt != 32 || ra !== 1'b1) begin
      failures++;
      $display("FAIL clr_len: cycles=%0d ready_after=%b want 32 1", cnt, ra);
    end
    do_req(1'b0, 2'd2, 1'b0, 7'h20, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      failures++;
      $display("FAIL clr_zero: v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
  endtask

  task automatic test_reset_mid;
    logic r, v, e, ra, rdy;
    logic [W-1:0] d;
    int cnt;
    do_req(1'b1, 2'd2, 1'b0, 7'h30, 32'h12345678, r, v, d, e);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 7'h30;
    #1 rdy = req_ready;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (rdy !== 1'b0 || resp_valid !== 1'b0 || init_busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid: rdy=%b v=%b busy=%b want 0 0 1", rdy, resp_valid, init_busy);
    end
    count_busy(cnt, ra);
    do_req(1'b0, 2'd2, 1'b0, 7'h30, '0, r, v, d, e);
    checks++;
    if (cnt != 32 || v !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL rst_clear: cycles=%0d v=%b d=%h want 32 1 00000000", cnt, v, d);
    end
  endtask

`ifdef DATA_MEMORY_LSU_PARITY_EN
  task automatic test_parity;
    logic r, v, e;
    logic [W-1:0] d;
    do_req(1'b1, 2'd2, 1'b0, 7'h0C, 32'h000000FF, r, v, d, e);
    do_req(1'b0, 2'd2, 1'b0, 7'h0C, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h000000FF || e !== 1'b0) begin
      failures++;
      $display("FAIL par_clean: v=%b d=%h e=%b want 1 000000ff 0", v, d, e);
    end
    @(negedge clk);
    dut.u_array.mem[3] = dut.u_array.mem[3] ^ 32'h1;
    do_req(1'b0, 2'd2, 1'b0, 7'h0C, '0, r, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h000000FE || e !== 1'b1) begin
      failures++;
      $display("FAIL par_flip: v=%b d=%h e=%b want 1 000000fe 1", v, d, e);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    test_reset();
    test_byte_ext();
    test_partial_store();
    test_misalign();
    test_back_to_back();
`ifdef DATA_MEMORY_LSU_PARITY_EN
    test_parity();
`endif
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
